// File: rtl/memory_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the shared block memory.
// The arbiter attaches through the slave modport; requesters and memory attach through master.
interface memory_port_arbiter_if #(
    parameter int ADDRESS_SIZE = 9
);
    logic                    fetch_req;
    logic [31:0]             fetch_address;
    logic                    fetch_done;
    logic [31:0]             fetch_data;

    logic                    data_req;
    logic                    data_write;
    logic [1:0]              data_size;
    logic [31:0]             data_address;
    logic [31:0]             data_write_data;
    logic                    data_done;
    logic [31:0]             data_read_data;
    logic                    data_error;

    logic                    mem_read_enable;
    logic                    mem_write_enable;
    logic [ADDRESS_SIZE-1:0] mem_address;
    logic [31:0]             mem_write_data;
    logic [31:0]             mem_read_data;

    logic [7:0]              memory_mapped_io;

    modport master (
        output fetch_req, fetch_address,
        input  fetch_done, fetch_data,
        output data_req, data_write, data_size, data_address, data_write_data,
        input  data_done, data_read_data, data_error,
        input  mem_read_enable, mem_write_enable, mem_address, mem_write_data,
        output mem_read_data,
        input  memory_mapped_io
    );

    modport slave (
        input  fetch_req, fetch_address,
        output fetch_done, fetch_data,
        input  data_req, data_write, data_size, data_address, data_write_data,
        output data_done, data_read_data, data_error,
        output mem_read_enable, mem_write_enable, mem_address, mem_write_data,
        input  mem_read_data,
        output memory_mapped_io
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one single-port block memory between instruction fetch and load/store, with
// round-robin tie-break, read-modify-write for sub-word stores, one MMIO byte and alignment checks.
module memory_port_arbiter #(
    parameter int          ADDRESS_SIZE = 9,
    parameter logic [31:0] MMIO_ADDRESS = 32'h0000_2000
) (
    input  logic                clk,
    input  logic                rst_n,
    memory_port_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_WAIT = 3'd1,
        LOAD_WAIT  = 3'd2,
        RMW_WRITE  = 3'd3,
        ACK        = 3'd4,
        ERR        = 3'd5
    } state_t;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic       GRANT_DATA = 1'b1;
    localparam logic       GRANT_FETCH = 1'b0;

    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: lane_mask = 32'h0000_00FF;
            SIZE_HALF: lane_mask = 32'h0000_FFFF;
            SIZE_WORD: lane_mask = 32'hFFFF_FFFF;
            default:   lane_mask = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = offset[0];
            SIZE_WORD: is_misaligned = (offset != 2'b00);
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] old_word, input logic [31:0] new_data,
                                               input logic [31:0] mask, input logic [4:0] shift);
        merge_lane = (old_word & ~(mask << shift)) | ((new_data & mask) << shift);
    endfunction

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_last_grant;
    logic                    r_active;
    logic                    r_fetch_done;
    logic                    r_data_done;
    logic                    r_data_error;
    logic [1:0]              r_size;
    logic [4:0]              r_shift;
    logic [31:0]             r_wdata;
    logic [ADDRESS_SIZE-1:0] r_word_addr;
    logic                    r_mmio_load;
    logic [7:0]              r_mmio;

    logic                    w_grant_fetch;
    logic                    w_grant_data;
    logic                    w_data_misaligned;
    logic                    w_data_is_mmio;
    logic                    w_data_mem_access;
    logic [ADDRESS_SIZE-1:0] w_fetch_word_addr;
    logic [ADDRESS_SIZE-1:0] w_data_word_addr;
    logic                    w_mem_read_enable;
    logic                    w_mem_write_enable;
    logic [ADDRESS_SIZE-1:0] w_mem_address;
    logic [31:0]             w_mem_write_data;
    logic [31:0]             w_fetch_data;
    logic [31:0]             w_data_read_data;
    logic                    w_unused;

    assign w_data_misaligned = is_misaligned(bus.data_size, bus.data_address[1:0]);
    assign w_data_is_mmio    = (bus.data_address == MMIO_ADDRESS);
    assign w_data_mem_access = w_grant_data && !w_data_misaligned && !w_data_is_mmio;
    assign w_fetch_word_addr = bus.fetch_address[ADDRESS_SIZE+1:2];
    assign w_data_word_addr  = bus.data_address[ADDRESS_SIZE+1:2];
    assign w_unused          = ^{bus.fetch_address[31:ADDRESS_SIZE+2], bus.fetch_address[1:0]};

    // Next-state and grant decode; requests are only looked at in IDLE
    always_comb begin
        w_next_state  = r_state;
        w_grant_fetch = 1'b0;
        w_grant_data  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_active && bus.fetch_req && (!bus.data_req || (r_last_grant == GRANT_DATA))) begin
                    w_grant_fetch = 1'b1;
                    w_next_state  = FETCH_WAIT;
                end else if (r_active && bus.data_req) begin
                    w_grant_data = 1'b1;
                    if (w_data_misaligned) begin
                        w_next_state = ERR;
                    end else if (w_data_is_mmio) begin
                        w_next_state = ACK;
                    end else if (!bus.data_write) begin
                        w_next_state = LOAD_WAIT;
                    end else if (bus.data_size == SIZE_WORD) begin
                        w_next_state = ACK;
                    end else begin
                        w_next_state = RMW_WRITE;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            FETCH_WAIT, LOAD_WAIT, RMW_WRITE, ACK, ERR: w_next_state = IDLE;
            default:                                    w_next_state = IDLE;
        endcase
    end

    // State register, grant history and the post-reset enable that keeps grants off during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_DATA;
            r_active     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_active <= 1'b1;
            if (w_grant_fetch) begin
                r_last_grant <= GRANT_FETCH;
            end else if (w_grant_data) begin
                r_last_grant <= GRANT_DATA;
            end
        end
    end

    // Completion flags registered from the next state so no request reaches done combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_data_error <= 1'b0;
        end else begin
            r_fetch_done <= (w_next_state == FETCH_WAIT);
            r_data_done  <= (w_next_state == LOAD_WAIT) || (w_next_state == RMW_WRITE) ||
                            (w_next_state == ACK && w_grant_data) || (w_next_state == ERR);
            r_data_error <= (w_next_state == ERR);
        end
    end

    // Capture of the granted data request for the second cycle of the transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size      <= 2'b00;
            r_shift     <= 5'd0;
            r_wdata     <= 32'h0000_0000;
            r_word_addr <= '0;
            r_mmio_load <= 1'b0;
        end else if (w_grant_data) begin
            r_size      <= bus.data_size;
            r_shift     <= {bus.data_address[1:0], 3'b000};
            r_wdata     <= bus.data_write_data;
            r_word_addr <= w_data_word_addr;
            r_mmio_load <= !w_data_misaligned && w_data_is_mmio && !bus.data_write;
        end
    end

    // IO register written at the grant edge of an aligned MMIO store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mmio <= 8'h00;
        end else if (w_grant_data && !w_data_misaligned && w_data_is_mmio && bus.data_write) begin
            r_mmio <= bus.data_write_data[7:0];
        end
    end

    // Memory enables: grant-cycle read/write from IDLE, or the merged write in RMW_WRITE
    always_comb begin
        w_mem_read_enable  = 1'b0;
        w_mem_write_enable = 1'b0;
        w_mem_address      = '0;
        w_mem_write_data   = 32'h0000_0000;
        if (w_grant_fetch) begin
            w_mem_read_enable = 1'b1;
            w_mem_address     = w_fetch_word_addr;
        end else if (w_data_mem_access) begin
            w_mem_address = w_data_word_addr;
            if (bus.data_write && (bus.data_size == SIZE_WORD)) begin
                w_mem_write_enable = 1'b1;
                w_mem_write_data   = bus.data_write_data;
            end else begin
                w_mem_read_enable = 1'b1;
            end
        end else if (r_state == RMW_WRITE) begin
            w_mem_write_enable = 1'b1;
            w_mem_address      = r_word_addr;
            w_mem_write_data   = merge_lane(bus.mem_read_data, r_wdata, lane_mask(r_size), r_shift);
        end else begin
            w_mem_read_enable  = 1'b0;
        end
    end

    // Read data steering, zero outside the completion states
    always_comb begin
        w_fetch_data     = 32'h0000_0000;
        w_data_read_data = 32'h0000_0000;
        if (r_state == FETCH_WAIT) begin
            w_fetch_data = bus.mem_read_data;
        end else if (r_state == LOAD_WAIT) begin
            w_data_read_data = (bus.mem_read_data >> r_shift) & lane_mask(r_size);
        end else if ((r_state == ACK) && r_mmio_load) begin
            w_data_read_data = {24'h00_0000, r_mmio};
        end else begin
            w_data_read_data = 32'h0000_0000;
        end
    end

    assign bus.fetch_done       = r_fetch_done;
    assign bus.fetch_data       = w_fetch_data;
    assign bus.data_done        = r_data_done;
    assign bus.data_error       = r_data_error;
    assign bus.data_read_data   = w_data_read_data;
    assign bus.mem_read_enable  = w_mem_read_enable;
    assign bus.mem_write_enable = w_mem_write_enable;
    assign bus.mem_address      = w_mem_address;
    assign bus.mem_write_data   = w_mem_write_data;
    assign bus.memory_mapped_io = r_mmio;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: table of load/store vectors plus hand-written
// sequences for fetch, fetch/data alternation and reset in the middle of a read-modify-write.
module tb_memory_port_arbiter;

    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    memory_port_arbiter_if #(.ADDRESS_SIZE(AW)) bus ();

    memory_port_arbiter #(.ADDRESS_SIZE(AW), .MMIO_ADDRESS(32'h0000_2000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural block memory, 1-cycle read latency, word 5 preloaded
    logic [31:0] mem [0:(1<<AW)-1];
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0000_0000;
            mem[5]        <= 32'hAABB_CCDD;
            mem_init_done <= 1'b1;
        end else begin
            if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_write_data;
            if (bus.mem_read_enable) bus.mem_read_data <= mem[bus.mem_address];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_data(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic err,
                           output int done_cyc, output int re_cyc, output int we_cyc,
                           output logic overlap);
        @(posedge clk); #1;
        bus.data_req = 1'b1; bus.data_write = wr; bus.data_size = sz;
        bus.data_address = addr; bus.data_write_data = wd;
        rd = 32'h0; err = 1'b0; done_cyc = 0; re_cyc = 0; we_cyc = 0; overlap = 1'b0;
        for (int c = 1; c <= 16 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.mem_read_enable && re_cyc == 0) re_cyc = c;
            if (bus.mem_write_enable && we_cyc == 0) we_cyc = c;
            if (bus.mem_read_enable && bus.mem_write_enable) overlap = 1'b1;
            if (bus.data_done) begin
                done_cyc = c; rd = bus.data_read_data; err = bus.data_error;
            end
        end
        @(posedge clk); #1;
        bus.data_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, output logic [31:0] fd,
                            output int done_cyc, output int re_cyc);
        @(posedge clk); #1;
        bus.fetch_req = 1'b1; bus.fetch_address = addr;
        fd = 32'h0; done_cyc = 0; re_cyc = 0;
        for (int c = 1; c <= 16 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.mem_read_enable && re_cyc == 0) re_cyc = c;
            if (bus.fetch_done) begin
                done_cyc = c; fd = bus.fetch_data;
            end
        end
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
    endtask

    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  exp_re;
        logic [3:0]  exp_we;
        logic [7:0]  exp_mmio;
    } vec_t;

    vec_t vecs [20];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        logic        err;
        logic        ov;
        int          dc, rc, wc;

        //        wr    sz     addr           wd             chk   exp_rd         err   re    we    mmio
        vecs[0]  = '{1'b0, 2'b00, 32'h0000_0016, 32'h0000_0000, 1'b1, 32'h0000_00BB, 1'b0, 4'd1, 4'd0, 8'h00};
        vecs[1]  = '{1'b0, 2'b01, 32'h0000_0016, 32'h0000_0000, 1'b1, 32'h0000_AABB, 1'b0, 4'd1, 4'd0, 8'h00};
        vecs[2]  = '{1'b1, 2'b00, 32'h0000_0015, 32'h0000_0011, 1'b0, 32'h0000_0000, 1'b0, 4'd1, 4'd2, 8'h00};
        vecs[3]  = '{1'b0, 2'b10, 32'h0000_0014, 32'h0000_0000, 1'b1, 32'hAABB_11DD, 1'b0, 4'd1, 4'd0, 8'h00};
        vecs[4]  = '{1'b1, 2'b01, 32'h0000_0016, 32'h0000_2233, 1'b0, 32'h0000_0000, 1'b0, 4'd1, 4'd2, 8'h00};
        vecs[5]  = '{1'b0, 2'b10, 32'h0000_0014, 32'h0000_0000, 1'b1, 32'h2233_11DD, 1'b0, 4'd1, 4'd0, 8'h00};
        vecs[6]  = '{1'b1, 2'b10, 32'h0000_0022, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b1, 4'd0, 4'd0, 8'h00};
        vecs[7]  = '{1'b0, 2'b01, 32'h0000_0015, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 4'd0, 4'd0, 8'h00};
        vecs[8]  = '{1'b0, 2'b11, 32'h0000_0014, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 4'd0, 4'd0, 8'h00};
        vecs[9]  = '{1'b1, 2'b10, 32'h0000_2000, 32'h0000_005A, 1'b0, 32'h0000_0000, 1'b0, 4'd0, 4'd0, 8'h5A};
        vecs[10] = '{1'b0, 2'b10, 32'h0000_2000, 32'h0000_0000, 1'b1, 32'h0000_005A, 1'b0, 4'd0, 4'd0, 8'h5A};
        vecs[11] = '{1'b0, 2'b00, 32'h0000_2000, 32'h0000_0000, 1'b1, 32'h0000_005A, 1'b0, 4'd0, 4'd0, 8'h5A};
        vecs[12] = '{1'b1, 2'b10, 32'h0000_0018, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b0, 4'd0, 4'd1, 8'h5A};
        vecs[13] = '{1'b0, 2'b10, 32'h0000_0018, 32'h0000_0000, 1'b1, 32'hCAFE_F00D, 1'b0, 4'd1, 4'd0, 8'h5A};
        vecs[14] = '{1'b0, 2'b00, 32'h0000_0017, 32'h0000_0000, 1'b1, 32'h0000_0022, 1'b0, 4'd1, 4'd0, 8'h5A};
        vecs[15] = '{1'b1, 2'b00, 32'h0000_0017, 32'hFFFF_FF99, 1'b0, 32'h0000_0000, 1'b0, 4'd1, 4'd2, 8'h5A};
        vecs[16] = '{1'b0, 2'b10, 32'h0000_0814, 32'h0000_0000, 1'b1, 32'h9933_11DD, 1'b0, 4'd1, 4'd0, 8'h5A};
        vecs[17] = '{1'b1, 2'b01, 32'h0000_0018, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 4'd1, 4'd2, 8'h5A};
        vecs[18] = '{1'b0, 2'b01, 32'h0000_001A, 32'h0000_0000, 1'b1, 32'h0000_CAFE, 1'b0, 4'd1, 4'd0, 8'h5A};
        vecs[19] = '{1'b1, 2'b10, 32'h0000_2001, 32'h0000_0077, 1'b0, 32'h0000_0000, 1'b1, 4'd0, 4'd0, 8'h5A};

        bus.fetch_req = 1'b0; bus.fetch_address = 32'h0;
        bus.data_req = 1'b0; bus.data_write = 1'b0; bus.data_size = 2'b00;
        bus.data_address = 32'h0; bus.data_write_data = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_fetch_done", {31'h0, bus.fetch_done}, 32'h0);
        check("reset_data_done", {31'h0, bus.data_done}, 32'h0);
        check("reset_data_error", {31'h0, bus.data_error}, 32'h0);
        check("reset_enables", {30'h0, bus.mem_read_enable, bus.mem_write_enable}, 32'h0);
        check("reset_mmio", {24'h0, bus.memory_mapped_io}, 32'h0);
        check("reset_read_data", bus.fetch_data | bus.data_read_data, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_fetch(32'h0000_0014, rd, dc, rc);
        check("fetch14_data", rd, 32'hAABB_CCDD);
        check("fetch14_done_cycle", dc, 32'd2);
        check("fetch14_read_cycle", rc, 32'd1);
        do_fetch(32'h0000_0017, rd, dc, rc);
        check("fetch17_ignores_low_bits", rd, 32'hAABB_CCDD);

        for (int i = 0; i < 20; i++) begin
            do_data(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, rd, err, dc, rc, wc, ov);
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("v%0d_error", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            check($sformatf("v%0d_done_cycle", i), dc, 32'd2);
            check($sformatf("v%0d_read_cycle", i), rc, 32'(vecs[i].exp_re));
            check($sformatf("v%0d_write_cycle", i), wc, 32'(vecs[i].exp_we));
            check($sformatf("v%0d_enable_overlap", i), {31'h0, ov}, 32'h0);
            check($sformatf("v%0d_mmio", i), {24'h0, bus.memory_mapped_io}, {24'h0, vecs[i].exp_mmio});
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), {31'h0, bus.data_done}, 32'h0);
        end

        // Reset asserted while the RMW write is pending must drop the write
        @(posedge clk); #1;
        bus.data_req = 1'b1; bus.data_write = 1'b1; bus.data_size = 2'b00;
        bus.data_address = 32'h0000_0014; bus.data_write_data = 32'h0000_0077;
        @(negedge clk);
        check("rmw_read_at_grant", {30'h0, bus.mem_read_enable, bus.mem_write_enable}, 32'h2);
        @(posedge clk); #2;
        check("rmw_write_pending", {30'h0, bus.mem_read_enable, bus.mem_write_enable}, 32'h1);
        rst_n = 1'b0;
        bus.data_req = 1'b0;
        #1;
        check("rmw_reset_enables", {30'h0, bus.mem_read_enable, bus.mem_write_enable}, 32'h0);
        check("rmw_reset_dones", {29'h0, bus.fetch_done, bus.data_done, bus.data_error}, 32'h0);
        check("rmw_reset_mmio", {24'h0, bus.memory_mapped_io}, 32'h0);
        check("rmw_reset_read_data", bus.fetch_data | bus.data_read_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        do_data(1'b0, 2'b10, 32'h0000_0014, 32'h0, rd, err, dc, rc, wc, ov);
        check("rmw_reset_word5_unchanged", rd, 32'h9933_11DD);
        do_data(1'b0, 2'b10, 32'h0000_2000, 32'h0, rd, err, dc, rc, wc, ov);
        check("rmw_reset_mmio_load", rd, 32'h0000_0000);

        // Both requesters held continuously right after reset: fetch first, then alternate
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.fetch_req = 1'b1; bus.fetch_address = 32'h0000_0014;
        bus.data_req = 1'b1; bus.data_write = 1'b0; bus.data_size = 2'b10;
        bus.data_address = 32'h0000_0018; bus.data_write_data = 32'h0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("alt%0d_fetch_done", c), {31'h0, bus.fetch_done}, {31'h0, (c % 4) == 1});
            check($sformatf("alt%0d_data_done", c), {31'h0, bus.data_done}, {31'h0, (c % 4) == 3});
            check($sformatf("alt%0d_read_enable", c), {31'h0, bus.mem_read_enable}, {31'h0, (c % 2) == 0});
            if ((c % 4) == 1) check($sformatf("alt%0d_fetch_data", c), bus.fetch_data, 32'h9933_11DD);
            if ((c % 4) == 3) check($sformatf("alt%0d_load_data", c), bus.data_read_data, 32'hCAFE_5678);
        end
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
        bus.data_req = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
